// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer: FSM state encodings and
// the bit-counter width helper.
package piso_serializer_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake plus serial output bundle between the data register
// (master) and the serializer (slave).
interface piso_serializer_if #(
   parameter int WIDTH = 4
) ();
   logic [WIDTH-1:0] data;
   logic             load_valid;
   logic             load_ready;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             done;

   modport master (
      output data, load_valid,
      input  load_ready, sout, sout_valid, busy, done
   );

   modport slave (
      input  data, load_valid,
      output load_ready, sout, sout_valid, busy, done
   );
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Frame bit counter: cleared on accept, advances once per shifted bit and
// saturates at WIDTH-1 so it can never roll into a second frame.
module piso_serializer_bit_counter
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr_i,
   input  logic                      en_i,
   output logic [cnt_w(WIDTH)-1:0]   cnt_o,
   output logic                      last_o
);
   localparam int               CNT_W    = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_LAST)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == CNT_LAST);
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter: captures a word on load handshake,
// shifts it out one bit per clock, optional even parity, then a done pulse.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int MSB_FIRST  = 1,
   parameter int PARITY_EN  = 0,
   parameter int IDLE_LEVEL = 0
) (
   input  logic               clk,
   input  logic               rst,
   piso_serializer_if.slave   s_if
);
   localparam int   CNT_W    = cnt_w(WIDTH);
   localparam logic IDLE_BIT = IDLE_LEVEL[0];

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic             par_q, par_d;
   logic             sout_q, sout_d;
   logic             sout_valid_q, sout_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load_ready_q, load_ready_d;
   logic             cnt_clr, cnt_en, cnt_last;
   logic [CNT_W-1:0] cnt;
   logic             unused_cnt;

   piso_serializer_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .cnt_o  (cnt),
      .last_o (cnt_last)
   );

   assign unused_cnt = ^cnt;

   always_comb begin
      state_d      = state_q;
      sreg_d       = sreg_q;
      par_d        = par_q;
      sout_d       = IDLE_BIT;
      sout_valid_d = 1'b0;
      busy_d       = busy_q;
      done_d       = 1'b0;
      load_ready_d = load_ready_q;
      cnt_clr      = 1'b0;
      cnt_en       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy_d       = 1'b0;
            load_ready_d = 1'b1;
            if (s_if.load_valid && load_ready_q) begin
               sreg_d       = s_if.data;
               par_d        = 1'b0;
               sout_d       = (MSB_FIRST != 0) ? s_if.data[WIDTH-1] : s_if.data[0];
               sout_valid_d = 1'b1;
               busy_d       = 1'b1;
               load_ready_d = 1'b0;
               cnt_clr      = 1'b1;
               state_d      = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_last) begin
               // par_q covers every bit but the one now on sout
               if (PARITY_EN != 0) begin
                  sout_d       = par_q ^ sout_q;
                  sout_valid_d = 1'b1;
                  state_d      = ST_PARITY;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end else begin
               sreg_d       = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0}
                                               : {1'b0, sreg_q[WIDTH-1:1]};
               sout_d       = (MSB_FIRST != 0) ? sreg_q[WIDTH-2] : sreg_q[1];
               sout_valid_d = 1'b1;
               par_d        = par_q ^ sout_q;
               cnt_en       = 1'b1;
            end
         end
         ST_PARITY: begin
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            busy_d       = 1'b0;
            load_ready_d = 1'b1;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d      = ST_IDLE;
            sreg_d       = '0;
            par_d        = 1'b0;
            busy_d       = 1'b0;
            load_ready_d = 1'b1;
            cnt_clr      = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sreg_q       <= '0;
         par_q        <= 1'b0;
         sout_q       <= IDLE_BIT;
         sout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         sreg_q       <= sreg_d;
         par_q        <= par_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         load_ready_q <= load_ready_d;
      end
   end

   assign s_if.sout       = sout_q;
   assign s_if.sout_valid = sout_valid_q;
   assign s_if.busy       = busy_q;
   assign s_if.done       = done_q;
   assign s_if.load_ready = load_ready_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three configurations (MSB-first,
// LSB-first, MSB-first with parity) checked by per-instance monitors.
module tb_piso_serializer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   piso_serializer_if #(.WIDTH(4)) ifa ();
   piso_serializer_if #(.WIDTH(4)) ifb ();
   piso_serializer_if #(.WIDTH(4)) ifc ();

   logic [3:0] d_a, d_b, d_c;
   logic       v_a, v_b, v_c;
   assign ifa.data = d_a;  assign ifa.load_valid = v_a;
   assign ifb.data = d_b;  assign ifb.load_valid = v_b;
   assign ifc.data = d_c;  assign ifc.load_valid = v_c;

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(0), .IDLE_LEVEL(0)) dut_a (
      .clk(clk), .rst(rst), .s_if(ifa));
   piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(0), .IDLE_LEVEL(0)) dut_b (
      .clk(clk), .rst(rst), .s_if(ifb));
   piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(1), .IDLE_LEVEL(0)) dut_c (
      .clk(clk), .rst(rst), .s_if(ifc));

   int n_tests = 0;
   int n_fail  = 0;
   int q0[$], q1[$], q2[$];

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // expected code per valid output cycle: 0/1 = serial bit, 2 = done pulse
   task automatic push_exp(int w, logic [7:0] bits, int n, bit with_done);
      for (int i = n - 1; i >= 0; i--) begin
         case (w)
            0: q0.push_back(int'(bits[i]));
            1: q1.push_back(int'(bits[i]));
            default: q2.push_back(int'(bits[i]));
         endcase
      end
      if (with_done) begin
         case (w)
            0: q0.push_back(2);
            1: q1.push_back(2);
            default: q2.push_back(2);
         endcase
      end
   endtask

   task automatic sb_pop(int w, logic [1:0] got, string name);
      int  exp;
      bit  empty;
      case (w)
         0: empty = (q0.size() == 0);
         1: empty = (q1.size() == 0);
         default: empty = (q2.size() == 0);
      endcase
      if (empty) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: unexpected output code %0d, nothing expected", name, got);
      end else begin
         case (w)
            0: exp = q0.pop_front();
            1: exp = q1.pop_front();
            default: exp = q2.pop_front();
         endcase
         check(name, 32'(got), 32'(exp));
      end
   endtask

   always @(negedge clk) begin
      if (ifa.sout_valid === 1'b1) sb_pop(0, {1'b0, ifa.sout}, "a_bit");
      if (ifa.done === 1'b1) sb_pop(0, 2'd2, "a_done");
      if (ifa.sout_valid === 1'b0) check("a_idle_sout", 32'(ifa.sout), 0);
      if (ifa.busy === 1'b1 && ifa.sout_valid === 1'b0) check("a_gap", 32'(ifa.done), 1);
   end

   always @(negedge clk) begin
      if (ifb.sout_valid === 1'b1) sb_pop(1, {1'b0, ifb.sout}, "b_bit");
      if (ifb.done === 1'b1) sb_pop(1, 2'd2, "b_done");
      if (ifb.sout_valid === 1'b0) check("b_idle_sout", 32'(ifb.sout), 0);
      if (ifb.busy === 1'b1 && ifb.sout_valid === 1'b0) check("b_gap", 32'(ifb.done), 1);
   end

   always @(negedge clk) begin
      if (ifc.sout_valid === 1'b1) sb_pop(2, {1'b0, ifc.sout}, "c_bit");
      if (ifc.done === 1'b1) sb_pop(2, 2'd2, "c_done");
      if (ifc.sout_valid === 1'b0) check("c_idle_sout", 32'(ifc.sout), 0);
      if (ifc.busy === 1'b1 && ifc.sout_valid === 1'b0) check("c_gap", 32'(ifc.done), 1);
   end

   function automatic logic rdy(int w);
      case (w)
         0: return ifa.load_ready;
         1: return ifb.load_ready;
         default: return ifc.load_ready;
      endcase
   endfunction

   task automatic set_in(int w, logic [3:0] d, logic v);
      case (w)
         0: begin d_a = d; v_a = v; end
         1: begin d_b = d; v_b = v; end
         default: begin d_c = d; v_c = v; end
      endcase
   endtask

   // holds load_valid until accepted; cyc = edges from call to accept edge
   task automatic send(int w, logic [3:0] d, output int cyc);
      logic r;
      cyc = 0;
      set_in(w, d, 1'b1);
      do begin
         @(negedge clk);
         r = rdy(w);
         @(posedge clk);
         #1;
         cyc++;
      end while (r !== 1'b1 && cyc < 40);
      if (r !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: dut %0d never ready, waited %0d cycles", w, cyc);
      end
      set_in(w, d, 1'b0);
   endtask

   task automatic wait_ready(int w);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (rdy(w) !== 1'b1 && k < 40);
      if (rdy(w) !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: dut %0d not ready after %0d cycles", w, k);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc;
      set_in(0, 4'h0, 1'b0);
      set_in(1, 4'h0, 1'b0);
      set_in(2, 4'h0, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_load_ready", 32'(ifa.load_ready), 1);
      check("rst_sout_valid", 32'(ifa.sout_valid), 0);
      check("rst_busy", 32'(ifa.busy), 0);
      check("rst_done", 32'(ifa.done), 0);
      check("rst_sout", 32'(ifa.sout), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // basic MSB-first frame with exact timing of valid, done and ready
      push_exp(0, 8'b1010, 4, 1'b1);
      send(0, 4'b1010, cyc);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("basic_valid", 32'(ifa.sout_valid), 1);
         check("basic_ready_low", 32'(ifa.load_ready), 0);
      end
      @(negedge clk);
      check("basic_done", 32'(ifa.done), 1);
      check("basic_done_busy", 32'(ifa.busy), 1);
      check("basic_done_ready", 32'(ifa.load_ready), 0);
      @(negedge clk);
      check("basic_after_ready", 32'(ifa.load_ready), 1);
      check("basic_after_done", 32'(ifa.done), 0);
      check("basic_after_busy", 32'(ifa.busy), 0);
      @(posedge clk);
      #1;

      // back-pressure: 1111 held valid during a 0101 frame
      push_exp(0, 8'b0101, 4, 1'b1);
      send(0, 4'b0101, cyc);
      push_exp(0, 8'b1111, 4, 1'b1);
      send(0, 4'b1111, cyc);
      check("bp_spacing", 32'(cyc), 6);
      wait_ready(0);

      // data toggles off-edge while the frame is in flight
      push_exp(0, 8'b0110, 4, 1'b1);
      send(0, 4'b0110, cyc);
      for (int i = 0; i < 6; i++) begin
         #10 d_a = ~d_a;
      end
      wait_ready(0);

      // reset after two bits of 1100: frame aborted, no done
      push_exp(0, 8'b11, 2, 1'b0);
      send(0, 4'b1100, cyc);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_sout", 32'(ifa.sout), 0);
      check("mid_rst_valid", 32'(ifa.sout_valid), 0);
      check("mid_rst_busy", 32'(ifa.busy), 0);
      check("mid_rst_ready", 32'(ifa.load_ready), 1);
      check("mid_rst_done", 32'(ifa.done), 0);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1;

      // LSB-first: 0001 -> 1,0,0,0
      push_exp(1, 8'b1000, 4, 1'b1);
      send(1, 4'b0001, cyc);
      wait_ready(1);

      // parity: 1011 -> 1,0,1,1,p=1 ; 1111 -> 1,1,1,1,p=0
      push_exp(2, 8'b10111, 5, 1'b1);
      send(2, 4'b1011, cyc);
      wait_ready(2);
      push_exp(2, 8'b11110, 5, 1'b1);
      send(2, 4'b1111, cyc);
      check("par_spacing_wait", 32'(cyc), 1);
      wait_ready(2);

      repeat (4) @(negedge clk);
      check("sb_a_empty", 32'(q0.size()), 0);
      check("sb_b_empty", 32'(q1.size()), 0);
      check("sb_c_empty", 32'(q2.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
